// File: rtl/weight_load_sched.sv
// rtl/weight_load_sched.sv - weight tile load sequencer for the systolic array weight FIFO bank
module weight_load_sched #(
  parameter int SYS_COLS = 4,
  parameter int W_ROWS   = 4,
  parameter int TILE_W   = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [TILE_W-1:0]         num_tiles,
  input  logic                      stall,
  input  logic                      array_ready,
  output logic                      buf_read,
  output logic                      load_en,
  output logic                      busy,
  output logic                      done,
  output logic [TILE_W-1:0]         tile_idx,
  output logic [$clog2(W_ROWS)-1:0] row_idx
);

  localparam int RW = $clog2(W_ROWS);
  localparam int CW = $clog2(W_ROWS + 1);
  localparam int DW = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1;
  localparam logic [CW-1:0] RD_LAST = CW'(W_ROWS);
  localparam logic [DW-1:0] DR_LAST = DW'(SYS_COLS - 1);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, SWAP, FIN} state_t;

  state_t            state;
  logic [TILE_W-1:0] n_lat;
  logic [CW-1:0]     rd_cnt;
  logic [DW-1:0]     dr_cnt;

  // Outputs are decided one edge ahead: each edge sets what the next cycle shows,
  // so rd_cnt counts reads already issued for the current tile.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      n_lat    <= '0;
      rd_cnt   <= '0;
      dr_cnt   <= '0;
      buf_read <= 1'b0;
      load_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tile_idx <= '0;
      row_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tile_idx <= '0;
            row_idx  <= '0;
            rd_cnt   <= '0;
            if (num_tiles != '0) begin
              n_lat    <= num_tiles;
              busy     <= 1'b1;
              buf_read <= !stall;
              rd_cnt   <= CW'(!stall);
              state    <= FEED;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        FEED: begin
          if (rd_cnt == RD_LAST) begin
            buf_read <= 1'b0;
            row_idx  <= '0;
            rd_cnt   <= '0;
            dr_cnt   <= '0;
            state    <= DRAIN;
          end else begin
            buf_read <= !stall;
            if (!stall) begin
              row_idx <= RW'(rd_cnt);
              rd_cnt  <= rd_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          // The last drain edge already samples array_ready so the earliest load follows drain directly.
          if (dr_cnt == DR_LAST) begin
            load_en <= array_ready;
            state   <= SWAP;
          end else begin
            dr_cnt <= dr_cnt + DW'(1);
          end
        end
        SWAP: begin
          if (load_en) begin
            load_en <= 1'b0;
            if (tile_idx == n_lat - TILE_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              tile_idx <= tile_idx + TILE_W'(1);
              buf_read <= !stall;
              rd_cnt   <= CW'(!stall);
              state    <= FEED;
            end
          end else begin
            load_en <= array_ready;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_load_sched.sv
// tb/tb_weight_load_sched.sv - randomized bench for weight_load_sched against a tile schedule model
module tb_weight_load_sched;
  localparam int SC = 4;
  localparam int WR = 4;
  localparam int TW = 8;
  localparam int N  = 6000;

  logic          clk = 1'b0;
  logic          rstn, start, stall, array_ready;
  logic [TW-1:0] num_tiles;
  logic          buf_read, load_en, busy, done;
  logic [TW-1:0] tile_idx;
  logic [1:0]    row_idx;

  bit s_rstn[N], s_start[N], s_stall[N], s_rdy[N];
  int s_nt[N];
  bit e_rd[N], e_ld[N], e_busy[N], e_dn[N];
  int e_tile[N], e_row[N];
  bit tset[N], rset[N];
  int tval[N], rval[N];
  bit o_rd[N], o_ld[N], o_busy[N], o_dn[N];
  int o_tile[N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  weight_load_sched #(.SYS_COLS(SC), .W_ROWS(WR), .TILE_W(TW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_tiles(num_tiles), .stall(stall),
    .array_ready(array_ready), .buf_read(buf_read), .load_en(load_en), .busy(busy),
    .done(done), .tile_idx(tile_idx), .row_idx(row_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int sum(input int sel, input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++)
      case (sel)
        0: s += int'(o_rd[i]);
        1: s += int'(o_ld[i]);
        2: s += int'(o_dn[i]);
        default: s += int'(o_busy[i]);
      endcase
    return s;
  endfunction

  initial begin
    int c, cur, n, k, tcur, rcur, tmax;
    bit ab, ld;

    // Stimulus: cycle index c means inputs sampled at, and outputs launched by, the same edge.
    for (int i = 0; i < N; i++) begin
      s_rstn[i]  = !(i >= 1 && i <= 3);
      s_start[i] = 1'b0;
      s_stall[i] = 1'b0;
      s_rdy[i]   = 1'b1;
      s_nt[i]    = int'($urandom_range(0, 255));
      if (i >= 200) begin
        s_stall[i] = ($urandom_range(0, 4) == 0);
        s_rdy[i]   = ($urandom_range(0, 9) < 7);
        s_nt[i]    = int'($urandom_range(0, 4));
        if (i < N - 400) s_start[i] = ($urandom_range(0, 11) == 0);
        if (i >= 4500) s_rstn[i] = ($urandom_range(0, 149) != 0);
      end
    end
    s_start[11] = 1; s_nt[11] = 1;
    s_start[31] = 1; s_nt[31] = 3;
    s_start[71] = 1; s_nt[71] = 1; s_stall[72] = 1; s_stall[73] = 1;
    s_start[91] = 1; s_nt[91] = 1;
    for (int i = 91; i <= 103; i++) s_rdy[i] = 0;
    s_start[121] = 1; s_nt[121] = 0;
    s_start[131] = 1; s_nt[131] = 2; s_start[135] = 1; s_nt[135] = 5;
    s_start[161] = 1; s_nt[161] = 2; s_rstn[167] = 0;
    s_start[181] = 1; s_nt[181] = 1;
    s_start[200] = 1; s_nt[200] = 255;

    // Reference: walk each accepted run tile by tile (reads, drain, wait for ready, load).
    c = 1;
    while (c < N) begin
      if (!s_rstn[c] || !s_start[c]) begin
        c++;
        continue;
      end
      n = s_nt[c];
      tset[c] = 1; tval[c] = 0; rset[c] = 1; rval[c] = 0;
      if (n == 0) begin
        e_dn[c] = 1;
        c += 2;
        continue;
      end
      cur = c;
      ab = 0;
      for (int t = 0; t < n && !ab; t++) begin
        if (t > 0 && cur < N) begin tset[cur] = 1; tval[cur] = t; end
        k = 0;
        while (k < WR && !ab) begin
          if (cur >= N || !s_rstn[cur]) ab = 1;
          else begin
            e_busy[cur] = 1;
            if (!s_stall[cur]) begin e_rd[cur] = 1; rset[cur] = 1; rval[cur] = k; k++; end
            cur++;
          end
        end
        for (int d = 0; d < SC && !ab; d++) begin
          if (cur >= N || !s_rstn[cur]) ab = 1;
          else begin
            e_busy[cur] = 1;
            if (d == 0) begin rset[cur] = 1; rval[cur] = 0; end
            cur++;
          end
        end
        ld = 0;
        while (!ld && !ab) begin
          if (cur >= N || !s_rstn[cur]) ab = 1;
          else begin
            e_busy[cur] = 1;
            if (s_rdy[cur]) begin e_ld[cur] = 1; ld = 1; end
            cur++;
          end
        end
      end
      if (!ab && cur < N && s_rstn[cur]) begin
        e_dn[cur] = 1;
        c = cur + 2;
      end else begin
        c = cur;
      end
    end
    tcur = 0; rcur = 0;
    for (int i = 0; i < N; i++) begin
      if (!s_rstn[i]) begin tset[i] = 1; tval[i] = 0; rset[i] = 1; rval[i] = 0; end
      if (tset[i]) tcur = tval[i];
      if (rset[i]) rcur = rval[i];
      e_tile[i] = tcur;
      e_row[i]  = rcur;
    end

    for (int i = 1; i < N; i++) begin
      rstn        = s_rstn[i];
      start       = s_start[i];
      stall       = s_stall[i];
      array_ready = s_rdy[i];
      num_tiles   = TW'(s_nt[i]);
      @(posedge clk);
      #1;
      cyc = i;
      o_rd[i] = buf_read; o_ld[i] = load_en; o_busy[i] = busy; o_dn[i] = done;
      o_tile[i] = int'(tile_idx);
      check("buf_read", 32'(buf_read), 32'(e_rd[i]));
      check("load_en", 32'(load_en), 32'(e_ld[i]));
      check("busy", 32'(busy), 32'(e_busy[i]));
      check("done", 32'(done), 32'(e_dn[i]));
      check("tile_idx", 32'(tile_idx), 32'(e_tile[i]));
      check("row_idx", 32'(row_idx), 32'(e_row[i]));
      check("rd_ld_excl", 32'(buf_read & load_en), 32'd0);
    end

    cyc = N;
    check("basic_reads", sum(0, 11, 14), 4);
    check("basic_no_late_reads", sum(0, 15, 30), 0);
    check("basic_load9", 32'(o_ld[19]), 1);
    check("basic_one_load", sum(1, 11, 30), 1);
    check("basic_done10", 32'(o_dn[20]), 1);
    check("basic_busy1_9", sum(3, 11, 19), 9);
    check("basic_busy_off", 32'(o_busy[20]), 0);
    check("multi_load9", 32'(o_ld[39]), 1);
    check("multi_load18", 32'(o_ld[48]), 1);
    check("multi_load27", 32'(o_ld[57]), 1);
    check("multi_loads", sum(1, 31, 60), 3);
    check("multi_reads", sum(0, 31, 60), 12);
    check("multi_done28", 32'(o_dn[58]), 1);
    check("multi_tile1", 32'(o_tile[40]), 1);
    check("multi_tile2", 32'(o_tile[49]), 2);
    check("stall_reads", sum(0, 71, 80), 4);
    check("stall_read4", 32'(o_rd[74] & o_rd[75] & o_rd[76] & o_rd[71]), 1);
    check("stall_load11", 32'(o_ld[81]), 1);
    check("bp_load14", 32'(o_ld[104]), 1);
    check("bp_one_load", sum(1, 91, 110), 1);
    check("bp_no_reads", sum(0, 95, 104), 0);
    check("zero_done1", 32'(o_dn[121]), 1);
    check("zero_quiet", sum(0, 121, 130) + sum(1, 121, 130) + sum(3, 121, 130), 0);
    check("ign_loads", sum(1, 131, 160), 2);
    check("ign_dones", sum(2, 131, 160), 1);
    check("rst_quiet", sum(0, 167, 180) + sum(1, 167, 180) + sum(2, 167, 180) + sum(3, 167, 180), 0);
    check("rst_restart_load", 32'(o_ld[189]), 1);
    check("rst_restart_done", 32'(o_dn[190]), 1);
    tmax = 0;
    for (int i = 200; i < 4500; i++) if (o_tile[i] > tmax) tmax = o_tile[i];
    check("big_run_last_tile", tmax, 254);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
